// File: rtl/booth_pp_sequencer_pkg.sv
// Shared types and helpers for the radix-4 Booth partial-product datapath.
package booth_pp_sequencer_pkg;

    // Signed Booth digit after recoding one multiplier triplet.
    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_digit_t;

    // Sequencer control state.
    typedef enum logic {
        IDLE,
        EMIT
    } seqState_t;

    // Width of one sign-extension-encoded partial product.
    function automatic int ppWidth(input int width);
        return width + 5;
    endfunction

    // Radix-4 recoding of {y[2i+1], y[2i], y[2i-1]}.
    function automatic booth_digit_t decodeTriplet(input logic [2:0] triplet);
        booth_digit_t digit;
        case (triplet)
            3'b001, 3'b010: digit = POS1;
            3'b011:         digit = POS2;
            3'b100:         digit = NEG2;
            3'b101, 3'b110: digit = NEG1;
            default:        digit = ZERO;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/booth_pp_encode.sv
// Combinational radix-4 Booth partial-product encoder: one triplet and the
// multiplicand in, the raw pp, its +1 correction and the sign-extension
// encoded word out. Shared with the planned parallel array multiplier.
module booth_pp_encode
    import booth_pp_sequencer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       triplet,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic             signedMode,
    input  logic             firstDigit,
    output logic [WIDTH+1:0] ppRaw,
    output logic             ppNeg,
    output logic             ppSign,
    output logic [WIDTH+4:0] ppData
);

    localparam int P = WIDTH + 2;

    booth_digit_t   digit;
    logic [P-1:0]   aExt;
    logic [P-1:0]   magnitude;

    // Select 0/A/2A from the recoded digit and invert for negative digits.
    // NOTE: every combinational output gets a default before the case so no
    // path through the block leaves a value unassigned and infers a latch.
    always_comb begin
        magnitude = '0;
        ppNeg     = 1'b0;
        digit     = decodeTriplet(triplet);
        aExt      = signedMode ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                               : {2'b00, multiplicand};
        case (digit)
            POS1: magnitude = aExt;
            POS2: magnitude = aExt << 1;
            NEG1: begin
                magnitude = aExt;
                ppNeg     = 1'b1;
            end
            NEG2: begin
                magnitude = aExt << 1;
                ppNeg     = 1'b1;
            end
            default: magnitude = '0;
        endcase
        ppRaw = ppNeg ? ~magnitude : magnitude;
    end

    // Sign is taken after inversion; the +1 for negation travels separately.
    assign ppSign = ppRaw[P-1];

    // The lowest pp carries the full sign-extension constant, the others the
    // compact 1,~s prefix.
    assign ppData = firstDigit ? {~ppSign, ppSign, ppSign, ppRaw}
                               : {1'b0, 1'b1, ~ppSign, ppRaw};

endmodule

// File: rtl/booth_pp_sequencer.sv
// Sequential radix-4 Booth partial-product generator: latches one operand
// pair, then streams one encoded partial product per accepted beat.
module booth_pp_sequencer
    import booth_pp_sequencer_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NPP_MAX = WIDTH / 2 + 1,
    parameter int IDXW    = $clog2(WIDTH / 2 + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             pp_valid,
    input  logic             pp_ready,
    output logic [WIDTH+4:0] pp_data,
    output logic             pp_neg,
    output logic [IDXW-1:0]  pp_idx,
    output logic             pp_last
);

    localparam int PPW = ppWidth(WIDTH);
    localparam logic [IDXW-1:0] LAST_SIGNED   = IDXW'(WIDTH / 2 - 1);
    localparam logic [IDXW-1:0] LAST_UNSIGNED = IDXW'(NPP_MAX - 1);

    seqState_t        stateQ;
    seqState_t        stateD;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic             signedReg;
    logic [IDXW-1:0]  idxQ;
    logic [PPW-1:0]   ppDataQ;
    logic             ppNegQ;
    logic             ppLastQ;

    logic             accept;
    logic             advance;
    logic [WIDTH-1:0] encA;
    logic [WIDTH-1:0] encB;
    logic             encSigned;
    logic [IDXW-1:0]  encIdx;
    logic [WIDTH+2:0] yExt;
    logic [2:0]       encTriplet;
    logic             encLast;
    logic [WIDTH+1:0] encRaw;
    logic             encNeg;
    logic             encSign;
    logic [PPW-1:0]   encData;
    logic             unusedEncodeBits;

    assign accept  = (stateQ == IDLE) && in_valid;
    assign advance = (stateQ == EMIT) && pp_ready;

    // In IDLE the encoder looks at the incoming operands so digit 0 can be
    // registered at acceptance; in EMIT it precomputes the next digit.
    assign encA      = (stateQ == IDLE) ? in_a      : aReg;
    assign encB      = (stateQ == IDLE) ? in_b      : bReg;
    assign encSigned = (stateQ == IDLE) ? in_signed : signedReg;
    assign encIdx    = (stateQ == IDLE) ? '0 : idxQ + IDXW'(1);

    // Multiplier with y[-1]=0 below and two copies of the mode-dependent
    // extension bit above, so every digit's triplet is a 3-bit slice.
    assign yExt       = {{2{encSigned & encB[WIDTH-1]}}, encB, 1'b0};
    assign encTriplet = 3'(yExt >> {encIdx, 1'b0});
    assign encLast    = (encIdx == (encSigned ? LAST_SIGNED : LAST_UNSIGNED));

    booth_pp_encode #(
        .WIDTH(WIDTH)
    ) u_encode (
        .triplet     (encTriplet),
        .multiplicand(encA),
        .signedMode  (encSigned),
        .firstDigit  (stateQ == IDLE),
        .ppRaw       (encRaw),
        .ppNeg       (encNeg),
        .ppSign      (encSign),
        .ppData      (encData)
    );

    // Raw pp and sign are only needed by array-style users of the encoder.
    assign unusedEncodeBits = ^{encRaw, encSign};

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        stateD   = stateQ;
        in_ready = 1'b0;
        pp_valid = 1'b0;
        case (stateQ)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    stateD = EMIT;
                end
            end
            EMIT: begin
                pp_valid = 1'b1;
                if (pp_ready && ppLastQ) begin
                    stateD = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    // Operand latches and registered partial-product outputs.
    // NOTE: the operand latches are reset along with the outputs so nothing
    // from an aborted operation survives into the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aReg      <= '0;
            bReg      <= '0;
            signedReg <= 1'b0;
            idxQ      <= '0;
            ppDataQ   <= '0;
            ppNegQ    <= 1'b0;
            ppLastQ   <= 1'b0;
        end else if (accept) begin
            aReg      <= in_a;
            bReg      <= in_b;
            signedReg <= in_signed;
            idxQ      <= '0;
            ppDataQ   <= encData;
            ppNegQ    <= encNeg;
            ppLastQ   <= encLast;
        end else if (advance) begin
            if (ppLastQ) begin
                idxQ    <= '0;
                ppDataQ <= '0;
                ppNegQ  <= 1'b0;
                ppLastQ <= 1'b0;
            end else begin
                idxQ    <= encIdx;
                ppDataQ <= encData;
                ppNegQ  <= encNeg;
                ppLastQ <= encLast;
            end
        end
    end

    assign pp_data = ppDataQ;
    assign pp_neg  = ppNegQ;
    assign pp_idx  = idxQ;
    assign pp_last = ppLastQ;

endmodule

// File: tb/tb_booth_pp_sequencer.sv
// Self-checking bench for booth_pp_sequencer (WIDTH=8) against a digit-value
// reference model and the arithmetic product.
module tb_booth_pp_sequencer;

    localparam int WIDTH = 8;
    localparam int IDXW  = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             pp_valid;
    logic             pp_ready;
    logic [WIDTH+4:0] pp_data;
    logic             pp_neg;
    logic [IDXW-1:0]  pp_idx;
    logic             pp_last;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference stream and observed stream.
    logic [12:0] expData[8];
    logic        expNeg[8];
    int          expCount;
    logic [15:0] expProd;
    logic [12:0] obsData[8];
    logic        obsNeg[8];
    logic [2:0]  obsIdx[8];
    logic        obsLast[8];
    int          obsCount;

    booth_pp_sequencer #(
        .WIDTH(WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_signed(in_signed),
        .in_a     (in_a),
        .in_b     (in_b),
        .pp_valid (pp_valid),
        .pp_ready (pp_ready),
        .pp_data  (pp_data),
        .pp_neg   (pp_neg),
        .pp_idx   (pp_idx),
        .pp_last  (pp_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier bit y[k] with y[-1]=0 and mode-dependent extension above.
    function automatic int yBit(input logic [7:0] b, input bit sgn, input int k);
        if (k < 0) return 0;
        if (k >= WIDTH) return sgn ? int'(b[WIDTH-1]) : 0;
        return int'(b[k]);
    endfunction

    // Builds the expected pp stream from signed digit values.
    task automatic modelPps(input logic [7:0] a, input logic [7:0] b, input bit sgn);
        int aVal, bVal, d, mag;
        logic [9:0] m, p;
        logic s;
        aVal = sgn ? int'($signed(a)) : int'(a);
        bVal = sgn ? int'($signed(b)) : int'(b);
        expProd  = 16'(aVal * bVal);
        expCount = sgn ? WIDTH / 2 : WIDTH / 2 + 1;
        for (int i = 0; i < expCount; i++) begin
            d = -2 * yBit(b, sgn, 2 * i + 1) + yBit(b, sgn, 2 * i) + yBit(b, sgn, 2 * i - 1);
            mag = (d < 0) ? -d : d;
            m = 10'(mag * aVal);
            p = (d < 0) ? ~m : m;
            expNeg[i] = (d < 0);
            s = p[9];
            expData[i] = (i == 0) ? {~s, s, s, p} : {1'b0, 1'b1, ~s, p};
        end
    endtask

    task automatic recordBeat(output bit done);
        if (obsCount < 8) begin
            obsData[obsCount] = pp_data;
            obsNeg[obsCount]  = pp_neg;
            obsIdx[obsCount]  = pp_idx;
            obsLast[obsCount] = pp_last;
        end
        done = (pp_last === 1'b1);
        obsCount++;
    endtask

    // Compares observed stream with the model and checks the reconstructed sum.
    task automatic checkStream(input string name);
        logic [31:0] acc;
        int n;
        testsRun++;
        if (obsCount !== expCount) begin
            $display("FAIL %s count: got %0d pps, required %0d", name, obsCount, expCount);
            testsFailed++;
        end
        n = (obsCount < expCount) ? obsCount : expCount;
        acc = '0;
        for (int i = 0; i < n; i++) begin
            testsRun++;
            if (obsData[i] !== expData[i] || obsNeg[i] !== expNeg[i] ||
                obsIdx[i] !== 3'(i) || obsLast[i] !== (i == expCount - 1)) begin
                $display("FAIL %s beat %0d: data=%h neg=%b idx=%0d last=%b, required data=%h neg=%b idx=%0d last=%b",
                         name, i, obsData[i], obsNeg[i], obsIdx[i], obsLast[i],
                         expData[i], expNeg[i], i, (i == expCount - 1));
                testsFailed++;
            end
            acc = acc + (32'(obsData[i]) << (2 * int'(obsIdx[i])))
                      + (32'(obsNeg[i]) << (2 * int'(obsIdx[i])));
        end
        testsRun++;
        if (acc[15:0] !== expProd) begin
            $display("FAIL %s sum: got %h, required %h", name, acc[15:0], expProd);
            testsFailed++;
        end
    endtask

    // Runs one operation end to end, optionally with random backpressure.
    task automatic runOp(input logic [7:0] a, input logic [7:0] b, input bit sgn,
                         input bit randReady, input string name);
        int waitCycles = 0;
        bit done = 1'b0;
        bit gapSeen = 1'b0;
        bit firstLate = 1'b0;
        modelPps(a, b, sgn);
        obsCount = 0;
        while (in_ready !== 1'b1 && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        testsRun++;
        if (in_ready !== 1'b1) begin
            $display("FAIL %s accept: in_ready=%b, required 1", name, in_ready);
            testsFailed++;
        end
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = sgn;
        @(negedge clk);
        in_valid  = 1'b0;
        in_a      = 8'($urandom);
        in_b      = 8'($urandom);
        in_signed = 1'($urandom);
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            pp_ready = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (cyc == 0 && pp_valid !== 1'b1) firstLate = 1'b1;
            if (pp_valid === 1'b1 && pp_ready) begin
                if (cyc != obsCount) gapSeen = 1'b1;
                recordBeat(done);
            end
            @(negedge clk);
        end
        pp_ready = 1'b0;
        testsRun++;
        if (!done) begin
            $display("FAIL %s timeout: pp_last not seen, %0d pps", name, obsCount);
            testsFailed++;
        end
        if (!randReady) begin
            testsRun++;
            if (firstLate || gapSeen) begin
                $display("FAIL %s timing: late_first=%b gap=%b, required 0/0", name, firstLate, gapSeen);
                testsFailed++;
            end
        end
        testsRun++;
        if (in_ready !== 1'b1 || pp_valid !== 1'b0) begin
            $display("FAIL %s idle after last: in_ready=%b pp_valid=%b, required 1/0", name, in_ready, pp_valid);
            testsFailed++;
        end
        checkStream(name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        testsRun++;
        if (in_ready !== 1'b1 || pp_valid !== 1'b0 || pp_data !== '0 ||
            pp_neg !== 1'b0 || pp_idx !== '0 || pp_last !== 1'b0) begin
            $display("FAIL reset: rdy=%b vld=%b data=%h neg=%b idx=%0d last=%b, required 1/0/0/0/0/0",
                     in_ready, pp_valid, pp_data, pp_neg, pp_idx, pp_last);
            testsFailed++;
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        testsRun++;
        if (in_ready !== 1'b1 || pp_valid !== 1'b0) begin
            $display("FAIL post-reset idle: in_ready=%b pp_valid=%b, required 1/0", in_ready, pp_valid);
            testsFailed++;
        end
    endtask

    task automatic test_signed_small();
        logic [12:0] want[4];
        want = '{13'h1003, 13'h0C03, 13'h0C00, 13'h0C00};
        runOp(8'd3, 8'd5, 1'b1, 1'b0, "signed_3x5");
        for (int i = 0; i < 4; i++) begin
            testsRun++;
            if (obsData[i] !== want[i] || obsNeg[i] !== 1'b0) begin
                $display("FAIL signed_3x5 const %0d: data=%h neg=%b, required %h/0", i, obsData[i], obsNeg[i], want[i]);
                testsFailed++;
            end
        end
    endtask

    task automatic test_signed_min();
        logic [12:0] want[4];
        logic        wantNeg[4];
        want    = '{13'h1000, 13'h0C00, 13'h0C00, 13'h0CFF};
        wantNeg = '{1'b0, 1'b0, 1'b0, 1'b1};
        runOp(8'h80, 8'h80, 1'b1, 1'b0, "signed_min");
        for (int i = 0; i < 4; i++) begin
            testsRun++;
            if (obsData[i] !== want[i] || obsNeg[i] !== wantNeg[i]) begin
                $display("FAIL signed_min const %0d: data=%h neg=%b, required %h/%b",
                         i, obsData[i], obsNeg[i], want[i], wantNeg[i]);
                testsFailed++;
            end
        end
        testsRun++;
        if (expProd !== 16'd16384) begin
            $display("FAIL signed_min product: model %0d, required 16384", expProd);
            testsFailed++;
        end
    endtask

    task automatic test_unsigned_max();
        runOp(8'hFF, 8'hFF, 1'b0, 1'b0, "unsigned_max");
        testsRun++;
        if (obsData[0] !== 13'h0F00 || obsNeg[0] !== 1'b1) begin
            $display("FAIL unsigned_max idx0: data=%h neg=%b, required 0f00/1", obsData[0], obsNeg[0]);
            testsFailed++;
        end
        testsRun++;
        if (obsData[4] !== 13'h0CFF || obsNeg[4] !== 1'b0 || obsLast[4] !== 1'b1) begin
            $display("FAIL unsigned_max idx4: data=%h neg=%b last=%b, required 0cff/0/1",
                     obsData[4], obsNeg[4], obsLast[4]);
            testsFailed++;
        end
    endtask

    task automatic test_backpressure();
        bit done = 1'b0;
        bit stalled = 1'b0;
        logic [12:0] snapData;
        logic        snapNeg, snapLast;
        modelPps(8'h5A, 8'hC3, 1'b1);
        obsCount  = 0;
        in_valid  = 1'b1;
        in_a      = 8'h5A;
        in_b      = 8'hC3;
        in_signed = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            pp_ready = 1'b1;
            if (!stalled && pp_valid === 1'b1 && pp_idx == 3'd1) begin
                stalled  = 1'b1;
                pp_ready = 1'b0;
                snapData = pp_data;
                snapNeg  = pp_neg;
                snapLast = pp_last;
                repeat (3) begin
                    in_valid  = 1'b1;
                    in_a      = 8'($urandom);
                    in_b      = 8'($urandom);
                    in_signed = 1'($urandom);
                    @(negedge clk);
                    testsRun++;
                    if (pp_valid !== 1'b1 || pp_data !== snapData || pp_neg !== snapNeg ||
                        pp_idx !== 3'd1 || pp_last !== snapLast || in_ready !== 1'b0) begin
                        $display("FAIL backpressure hold: vld=%b data=%h neg=%b idx=%0d rdy=%b, required 1/%h/%b/1/0",
                                 pp_valid, pp_data, pp_neg, pp_idx, in_ready, snapData, snapNeg);
                        testsFailed++;
                    end
                end
                in_valid = 1'b0;
                pp_ready = 1'b1;
            end
            if (pp_valid === 1'b1) recordBeat(done);
            @(negedge clk);
        end
        pp_ready = 1'b0;
        testsRun++;
        if (!stalled || !done) begin
            $display("FAIL backpressure progress: stalled=%b done=%b, required 1/1", stalled, done);
            testsFailed++;
        end
        testsRun++;
        if (in_ready !== 1'b1 || pp_valid !== 1'b0) begin
            $display("FAIL backpressure idle: in_ready=%b pp_valid=%b, required 1/0", in_ready, pp_valid);
            testsFailed++;
        end
        checkStream("backpressure");
    endtask

    task automatic test_reset_mid_op();
        int cyc = 0;
        in_valid  = 1'b1;
        in_a      = 8'hB7;
        in_b      = 8'h6D;
        in_signed = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        pp_ready = 1'b1;
        while (!(pp_valid === 1'b1 && pp_idx == 3'd2) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        testsRun++;
        if (pp_valid !== 1'b1 || pp_idx !== 3'd2) begin
            $display("FAIL reset_mid_op reach idx2: vld=%b idx=%0d, required 1/2", pp_valid, pp_idx);
            testsFailed++;
        end
        pp_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        testsRun++;
        if (pp_valid !== 1'b0 || pp_last !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL reset_mid_op async: vld=%b last=%b rdy=%b, required 0/0/1", pp_valid, pp_last, in_ready);
            testsFailed++;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            testsRun++;
            if (pp_valid !== 1'b0 || pp_last !== 1'b0 || in_ready !== 1'b1) begin
                $display("FAIL reset_mid_op after release: vld=%b last=%b rdy=%b, required 0/0/1",
                         pp_valid, pp_last, in_ready);
                testsFailed++;
            end
        end
        runOp(8'd3, 8'd5, 1'b1, 1'b0, "after_reset");
        testsRun++;
        if (obsData[0] !== 13'h1003 || obsIdx[0] !== 3'd0) begin
            $display("FAIL after_reset first pp: data=%h idx=%0d, required 1003/0", obsData[0], obsIdx[0]);
            testsFailed++;
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b;
        bit sgn;
        for (int n = 0; n < 1000; n++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            sgn = 1'($urandom);
            case ($urandom_range(0, 15))
                0: a = 8'h00;
                1: b = 8'h00;
                2: a = 8'h80;
                3: b = 8'hFF;
                default: ;
            endcase
            runOp(a, b, sgn, 1'b1, "random");
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        in_a      = '0;
        in_b      = '0;
        pp_ready  = 1'b0;
        test_reset();
        test_signed_small();
        test_signed_min();
        test_unsigned_max();
        runOp(8'h00, 8'h00, 1'b0, 1'b0, "zero_operands");
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/booth_pp_sequencer.md
Name: booth_pp_sequencer

Overview:
- Parametrised, sequential radix-4 Booth partial-product generator for the FMAC multiplier datapath.
- Accepts one operand pair over a valid/ready handshake.
- Emits one sign-extension-encoded partial product per cycle to the downstream compressor/accumulator, with a valid/ready handshake, digit index and last flag.
- Generalises the fixed 10-bit partial-product sign-extension mux to any even width, both signed and unsigned multiplier modes, and streaming output with backpressure.

Parameters:
- WIDTH, 8, operand width N; must be even and >= 4.
- NPP_MAX, WIDTH/2+1, partial products per operation in unsigned mode (signed mode uses WIDTH/2).
- IDXW, $clog2(WIDTH/2+1), width of pp_idx.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block idle, can accept.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled at acceptance.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier (Booth-recoded).
- pp_valid  out  1  partial product valid.
- pp_ready  in  1  downstream accepts.
- pp_data  out  WIDTH+5  sign-extension-encoded partial product.
- pp_neg  out  1  +1 correction bit, added at LSB of this pp's weight.
- pp_idx  out  IDXW  digit index i; weight is 4^i.
- pp_last  out  1  final partial product of the operation.

Behaviour:
- Reset (async assert, sync-to-clk deassert is handled externally):
  - State goes to IDLE.
  - pp_valid=0, pp_data=0, pp_neg=0, pp_idx=0, pp_last=0, in_ready=1.
  - A, B and mode registers cleared.
- States:
  - IDLE: in_ready=1. On in_valid, latch in_a, in_b and in_signed, set idx=0, go to EMIT.
  - EMIT: in_ready=0, pp_valid=1. On pp_valid && pp_ready: if idx==last_idx, go to IDLE; else idx+1.
- last_idx: WIDTH/2-1 if signed, WIDTH/2 if unsigned.
- Latency: first pp is valid the cycle after acceptance. Throughput is one pp per cycle when pp_ready=1. in_ready returns 1 the cycle after the last handshake.
- All pp_* outputs are registered, or forced to 0 whenever pp_valid=0.
- Booth digit i uses triplet {y[2i+1], y[2i], y[2i-1]}:
  - y[-1]=0.
  - y[k] for k>=WIDTH is B's sign bit when signed, 0 when unsigned.
  - Decode: 000,111 -> 0; 001,010 -> +1; 011 -> +2; 100 -> -2; 101,110 -> -1.
- Raw pp p has P=WIDTH+2 bits:
  - A is sign- or zero-extended to P bits per mode.
  - m = 0, A or 2A (shift left 1, truncated to P bits).
  - Negative digit: p=~m, pp_neg=1. Otherwise p=m, pp_neg=0. Digit 111 gives p=0, pp_neg=0.
- Sign s = p[P-1], i.e. taken after inversion and before +neg.
- Sign-extension encoding:
  - idx==0: pp_data = {~s, s, s, p}.
  - idx>0: pp_data = {1'b0, 1'b1, ~s, p}.
- Downstream sums pp_data<<2i plus pp_neg<<2i, modulo 2^(2N). The result equals A*B under the latched mode.
- Backpressure: while pp_valid && !pp_ready, every pp_* output is held stable.
- in_valid during EMIT is ignored and produces no side effects. in_a and in_b may change freely after acceptance.
- Zero operands: the full pp count is still emitted.
- Reset during EMIT aborts the operation immediately. No further pps are emitted and pp_last is never asserted for the aborted operation.

Decomposition:
- Shared fmac package holds:
  - booth_digit_t enum: ZERO, POS1, POS2, NEG1, NEG2.
  - State enum: IDLE, EMIT.
  - PPW = WIDTH+5 helper function.
- Sub-module booth_pp_encode (combinational): triplet + A + mode -> p, pp_neg, s, encoded pp_data. It is reusable by a future parallel array multiplier.

Test Plan:
- WIDTH=8, signed, A=3, B=5, pp_ready=1 -> 4 pps on consecutive cycles starting the cycle after acceptance:
  - idx0: 0x1003, neg 0.
  - idx1: 0x0C03, neg 0.
  - idx2: 0x0C00, neg 0.
  - idx3: 0x0C00, neg 0, last=1.
  - in_ready high the following cycle.
- Signed A=0x80, B=0x80 -> idx0–2 = 0x1000/0x0C00/0x0C00 with neg 0. idx3 = 0x0CFF with pp_neg=1 and last. Reconstructed sum = 16384.
- Unsigned A=0xFF, B=0xFF -> 5 pps:
  - idx0: 0x0F00, neg 1.
  - idx4: 0x0CFF, neg 0, last.
  - Sum mod 2^16 = 0xFE01.
- Backpressure: hold pp_ready=0 for 3 cycles at idx1 -> outputs stable. in_valid pulses during EMIT are ignored. The stream resumes at idx1.
- Reset mid-op: assert rst_n=0 asynchronously at idx2 -> pp_valid=0 immediately and in_ready=1 after release. The next operation starts at idx0 with correct values.
- Randomised scoreboard: 1000 random A/B/mode pairs with random pp_ready -> reconstructed sum equals A*B for every operation, and exactly one pp_last per operation.
